rp_mem_completer: RTL and testbench
===================================

// Module: rp_mem_completer
// PURPOSE
//  Root-port-side completer memory for the BMD simulation: the target of the endpoint's bus-master DMA.
//  Sinks Memory Write requests into a local dword memory.
//  Answers Memory Read requests with completions split at CPL_MAX_DW.
//  Sits behind the RP requester-side stream, in the simulation board, opposite the EP DMA engine.
// PARAMETERS
//  ADDR_W      10  memory depth = 2**ADDR_W dwords; request addresses wrap modulo depth
//  CPL_MAX_DW  16  max dwords per completion (power of 2, 1..64)
// PORTS
//  user_clk        in   1       sole clock
//  user_reset      in   1       synchronous, active-high reset
//  req_valid       in   1       request beat valid
//  req_ready       out  1       request beat accepted when valid&ready
//  req_sop         in   1       header beat; fields below sampled only on it
//  req_is_wr       in   1       1=MWr, 0=MRd
//  req_addr        in   ADDR_W  start dword address
//  req_len         in   10      length in dwords; 0 encodes 1024
//  req_tag         in   8       request tag
//  req_data        in   32      write payload dword (non-sop beats)
//  cpl_valid       out  1       completion beat valid
//  cpl_ready       in   1       completion beat consumed when valid&ready
//  cpl_sop         out  1       first beat of a completion; header fields valid
//  cpl_eop         out  1       last beat of a completion
//  cpl_tag         out  8       echoed request tag
//  cpl_byte_count  out  12      bytes remaining incl. this completion (4*dw; 1024 dw -> 0)
//  cpl_data        out  32      read payload dword
//  proto_err       out  1       sticky: sop seen mid-payload or non-sop beat in IDLE
//  wr_dw_cnt       out  32      total dwords written since reset (wraps)
// BEHAVIOUR
//  Reset: FSM=IDLE. cpl_valid, cpl_sop, cpl_eop, proto_err=0. cpl_tag, cpl_byte_count, cpl_data=0.
//   wr_dw_cnt=0. req_ready=0 during the reset cycle. Memory contents not reset.
//  FSM IDLE:
//   - sop&wr -> WR_DATA: latch addr, len (0->1024), tag.
//   - sop&rd -> RD_FETCH: latch the same.
//   - Non-sop beat: accepted and dropped; proto_err set.
//  FSM WR_DATA:
//   - req_ready=1. Each accepted beat writes req_data to mem[addr].
//   - Per beat: addr<=addr+1 mod depth, remaining--, wr_dw_cnt++.
//   - Last dword -> IDLE.
//   - Accepted sop beat: proto_err set, partial write abandoned, beat handled as new header.
//  FSM RD_FETCH:
//   - req_ready=0 for the whole read (RD_FETCH and RD_CPL).
//   - Issues a synchronous read of mem[addr]; 1-cycle RAM latency.
//   - -> RD_CPL.
//  FSM RD_CPL:
//   - Data presented from an output register; a 1-entry prefetch keeps throughput at 1 beat/clk under ready=1.
//   - Completion boundary: first completion ends at next CPL_MAX_DW-aligned address or end of request.
//     Subsequent completions are CPL_MAX_DW dwords, except a shorter final one.
//   - sop on first beat of each completion; byte_count = 4*remaining_dw (12-bit truncation).
//   - eop on the last beat of each completion.
//   - After the final dword is accepted -> IDLE; req_ready=1 the next cycle.
//  Latency: MRd header accepted at cycle T -> first cpl_valid at T+2.
//  Backpressure:
//   - cpl_ready=0: cpl_valid and all cpl_* fields held stable; no beat lost or duplicated.
//   - cpl_valid never drops without acceptance.
//  Address wrap:
//   - Reads and writes crossing 2**ADDR_W-1 continue at address 0.
//   - Completion split boundaries use the unwrapped address.
//  Write then read: a read issued the cycle after the final write beat returns the new data (write-first).
//  Reset mid-operation: FSM to IDLE next edge; in-flight request discarded; cpl_valid=0.
// TESTING
//  1. MWr addr=0x010 len=4 data 0xA0..0xA3, then MRd tag=0x05 same addr:
//     one completion sop+eop over 4 beats, byte_count=16, data 0xA0..0xA3, wr_dw_cnt=4.
//  2. MRd addr=0x00E len=20, CPL_MAX_DW=16:
//     completions of 2, 16, 2 dwords; byte_counts 80, 72, 8; tag echoed on each sop.
//  3. Repeat case 2 with cpl_ready toggled randomly 50%:
//     identical beat sequence; fields stable while stalled.
//  4. MWr addr=0x3FE len=4 (ADDR_W=10):
//     mem[0x3FE], mem[0x3FF], mem[0x000], mem[0x001] written; MRd readback matches.
//  5. MRd len=0: 1024 dwords in 64 completions; first byte_count=0 (4096 truncated), last=64.
//  6. Error and reset cases:
//     - sop during WR_DATA after 2 of 4 beats: proto_err=1; new header honoured.
//     - user_reset during RD_CPL: cpl_valid=0 next cycle; fresh MRd completes normally.

Source files
------------

// File: rtl/rp_mem_completer.sv
// Root-port completer memory: sinks Memory Write payload into a dword RAM and answers
// Memory Read requests with completions split at CPL_MAX_DW-aligned address boundaries.
module rp_mem_completer #(
  parameter int ADDR_W     = 10,
  parameter int CPL_MAX_DW = 16
) (
  input  logic              user_clk,
  input  logic              user_reset,
  // Both streams are valid/ready: a beat transfers on a rising edge where valid and
  // ready are both high. The source holds valid and every field stable until that
  // edge, and neither ready depends on the same-cycle valid of its stream.
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_sop,
  input  logic              req_is_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [9:0]        req_len,
  input  logic [7:0]        req_tag,
  input  logic [31:0]       req_data,
  output logic              cpl_valid,
  input  logic              cpl_ready,
  output logic              cpl_sop,
  output logic              cpl_eop,
  output logic [7:0]        cpl_tag,
  output logic [11:0]       cpl_byte_count,
  output logic [31:0]       cpl_data,
  output logic              proto_err,
  output logic [31:0]       wr_dw_cnt,
  output logic [1:0]        fsm_state
);

  localparam int                DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] CPL_MASK = ADDR_W'(CPL_MAX_DW - 1);
  localparam logic [10:0]       LEFT_ONE = 11'd1;
  localparam int                BEAT_W   = 46;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WR_DATA  = 2'd1,
    ST_RD_FETCH = 2'd2,
    ST_RD_CPL   = 2'd3
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [31:0]         mem [DEPTH];
  logic [ADDR_W-1:0]   cur_addr;
  logic [10:0]         left_q;
  logic                first_q;
  logic [7:0]          tag_q;
  logic                out_v;
  logic                skid_v;
  logic [BEAT_W-1:0]   out_beat;
  logic [BEAT_W-1:0]   skid_beat;
  logic [BEAT_W-1:0]   new_beat;
  logic                req_acc;
  logic                hdr_acc;
  logic                wr_acc;
  logic                err_beat;
  logic                rd_active;
  logic                pop;
  logic                room;
  logic                issue;
  logic                rd_done;
  logic                sop_n;
  logic                eop_n;

  assign req_ready = !user_reset && (state_q == ST_IDLE || state_q == ST_WR_DATA);
  assign req_acc   = req_valid && req_ready;
  assign hdr_acc   = req_acc && req_sop;
  assign wr_acc    = req_acc && !req_sop && (state_q == ST_WR_DATA);
  assign err_beat  = req_acc && (req_sop ? (state_q == ST_WR_DATA) : (state_q == ST_IDLE));

  // Read side: out_beat is the presented beat, skid_beat the one-entry prefetch.
  // A new RAM read is issued whenever the pair will not be full after this edge.
  assign rd_active = (state_q == ST_RD_FETCH) || (state_q == ST_RD_CPL);
  assign pop       = out_v && cpl_ready;
  assign room      = !(out_v && skid_v) || pop;
  assign issue     = rd_active && (left_q != 11'd0) && room;
  assign rd_done   = (state_q == ST_RD_CPL) && pop && !skid_v && (left_q == 11'd0);

  // Split points depend only on the low address bits, so the wrapped address
  // gives the same boundaries as the unwrapped one.
  assign sop_n    = first_q || ((cur_addr & CPL_MASK) == '0);
  assign eop_n    = (left_q == LEFT_ONE) || (((cur_addr + ADDR_ONE) & CPL_MASK) == '0);
  assign new_beat = {sop_n, eop_n, left_q[9:0], 2'b00, mem[cur_addr]};

  assign cpl_valid      = out_v;
  assign cpl_sop        = out_v && out_beat[45];
  assign cpl_eop        = out_v && out_beat[44];
  assign cpl_byte_count = out_beat[43:32];
  assign cpl_data       = out_beat[31:0];
  assign cpl_tag        = tag_q;
  assign fsm_state      = state_q;

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (hdr_acc) state_d = req_is_wr ? ST_WR_DATA : ST_RD_FETCH;
      end
      ST_WR_DATA: begin
        if (hdr_acc) begin
          state_d = req_is_wr ? ST_WR_DATA : ST_RD_FETCH;
        end else if (wr_acc && left_q == LEFT_ONE) begin
          state_d = ST_IDLE;
        end
      end
      ST_RD_FETCH: state_d = ST_RD_CPL;
      ST_RD_CPL: begin
        if (rd_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (wr_acc) mem[cur_addr] <= req_data;
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      cur_addr  <= '0;
      left_q    <= '0;
      first_q   <= 1'b0;
      tag_q     <= '0;
      proto_err <= 1'b0;
      wr_dw_cnt <= '0;
      out_v     <= 1'b0;
      out_beat  <= '0;
      skid_v    <= 1'b0;
      skid_beat <= '0;
    end else begin
      if (hdr_acc) begin
        cur_addr <= req_addr;
        left_q   <= {(req_len == 10'd0), req_len};
        first_q  <= 1'b1;
        tag_q    <= req_tag;
      end else if (wr_acc) begin
        cur_addr  <= cur_addr + ADDR_ONE;
        left_q    <= left_q - LEFT_ONE;
        wr_dw_cnt <= wr_dw_cnt + 32'd1;
      end else if (issue) begin
        cur_addr <= cur_addr + ADDR_ONE;
        left_q   <= left_q - LEFT_ONE;
        first_q  <= 1'b0;
      end

      if (err_beat) proto_err <= 1'b1;

      if (pop) begin
        if (skid_v) begin
          out_beat <= skid_beat;
          skid_v   <= issue;
          if (issue) skid_beat <= new_beat;
        end else begin
          out_v <= issue;
          if (issue) out_beat <= new_beat;
        end
      end else if (!out_v) begin
        out_v <= issue;
        if (issue) out_beat <= new_beat;
      end else if (issue) begin
        skid_v    <= 1'b1;
        skid_beat <= new_beat;
      end
    end
  end

endmodule

// File: tb/tb_rp_mem_completer.sv
// Self-checking bench for rp_mem_completer: directed cases plus randomized traffic,
// every completion beat compared against a queue built from a reference memory model.
module tb_rp_mem_completer;

  localparam int ADDR_W     = 10;
  localparam int CPL_MAX_DW = 16;
  localparam int DEPTH      = 1 << ADDR_W;

  logic              user_clk   = 1'b0;
  logic              user_reset = 1'b1;
  logic              req_valid  = 1'b0;
  logic              req_ready;
  logic              req_sop    = 1'b0;
  logic              req_is_wr  = 1'b0;
  logic [ADDR_W-1:0] req_addr   = '0;
  logic [9:0]        req_len    = '0;
  logic [7:0]        req_tag    = '0;
  logic [31:0]       req_data   = '0;
  logic              cpl_valid;
  logic              cpl_ready  = 1'b1;
  logic              cpl_sop;
  logic              cpl_eop;
  logic [7:0]        cpl_tag;
  logic [11:0]       cpl_byte_count;
  logic [31:0]       cpl_data;
  logic              proto_err;
  logic [31:0]       wr_dw_cnt;
  logic [1:0]        fsm_state;

  rp_mem_completer #(.ADDR_W(ADDR_W), .CPL_MAX_DW(CPL_MAX_DW)) dut (
    .user_clk       (user_clk),
    .user_reset     (user_reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_sop        (req_sop),
    .req_is_wr      (req_is_wr),
    .req_addr       (req_addr),
    .req_len        (req_len),
    .req_tag        (req_tag),
    .req_data       (req_data),
    .cpl_valid      (cpl_valid),
    .cpl_ready      (cpl_ready),
    .cpl_sop        (cpl_sop),
    .cpl_eop        (cpl_eop),
    .cpl_tag        (cpl_tag),
    .cpl_byte_count (cpl_byte_count),
    .cpl_data       (cpl_data),
    .proto_err      (proto_err),
    .wr_dw_cnt      (wr_dw_cnt),
    .fsm_state      (fsm_state)
  );

  // clock / reset
  always #5 user_clk = ~user_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference model: dword memory, write counter, expected beats {sop,eop,tag,bc,data}
  logic [31:0] model_mem [DEPTH];
  logic [31:0] model_wr_cnt = '0;
  logic [53:0] exp_q[$];
  int          exp_cpls   = 0;
  int          sop_seen   = 0;
  bit          stall_mode = 1'b0;
  bit          prev_stall = 1'b0;
  logic [53:0] prev_obs   = '0;
  logic [53:0] mon_obs;
  logic [53:0] mon_exp;

  task automatic model_read(input int addr, input int len, input logic [7:0] tag);
    int a;
    int rem;
    int chunk;
    logic [11:0] bc;
    a        = addr;
    rem      = (len == 0) ? 1024 : len;
    exp_cpls = 0;
    while (rem > 0) begin
      chunk = CPL_MAX_DW - (a % CPL_MAX_DW);
      if (chunk > rem) chunk = rem;
      bc = 12'((rem * 4) % 4096);
      for (int j = 0; j < chunk; j++) begin
        exp_q.push_back({(j == 0), (j == chunk - 1), tag, bc, model_mem[(a + j) % DEPTH]});
      end
      a   += chunk;
      rem -= chunk;
      exp_cpls++;
    end
  endtask

  // completion monitor / scoreboard
  always @(negedge user_clk) begin
    mon_obs = {cpl_sop, cpl_eop, cpl_tag, cpl_byte_count, cpl_data};
    if (user_reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check_eq("stall_valid", 64'(cpl_valid), 64'(1));
        check_eq("stall_fields", 64'(mon_obs), 64'(prev_obs));
      end
      if (cpl_valid && cpl_ready) begin
        check_eq("beat_expected", 64'(exp_q.size() != 0), 64'(1));
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          check_eq("cpl_data", 64'(cpl_data), 64'(mon_exp[31:0]));
          check_eq("cpl_sop", 64'(cpl_sop), 64'(mon_exp[53]));
          check_eq("cpl_eop", 64'(cpl_eop), 64'(mon_exp[52]));
          if (mon_exp[53]) begin
            check_eq("cpl_tag", 64'(cpl_tag), 64'(mon_exp[51:44]));
            check_eq("cpl_byte_count", 64'(cpl_byte_count), 64'(mon_exp[43:32]));
          end
          if (cpl_sop) sop_seen++;
        end
      end
      prev_stall = cpl_valid && !cpl_ready;
      prev_obs   = mon_obs;
    end
  end

  // completion backpressure driver
  initial begin
    forever begin
      @(posedge user_clk);
      #1;
      cpl_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // driver tasks: called at posedge+1, return at posedge+1 after the beat's edge
  task automatic drive_beat(input bit sop, input bit is_wr, input int addr, input int len,
                            input logic [7:0] tag, input logic [31:0] data);
    int cyc;
    cyc       = 0;
    req_valid = 1'b1;
    req_sop   = sop;
    req_is_wr = is_wr;
    req_addr  = ADDR_W'(addr);
    req_len   = 10'(len);
    req_tag   = tag;
    req_data  = data;
    do begin
      @(negedge user_clk);
      cyc++;
    end while (!req_ready && cyc < 200);
    if (!req_ready) check_eq("req_accept_timeout", 64'(req_ready), 64'(1));
    @(posedge user_clk);
    #1;
    req_valid = 1'b0;
    req_sop   = 1'b0;
  endtask

  task automatic send_write(input int addr, input int len, input logic [7:0] tag,
                            input bit rnd, input logic [31:0] base);
    int n;
    logic [31:0] d;
    n = (len == 0) ? 1024 : len;
    drive_beat(1'b1, 1'b1, addr, len, tag, 32'h0);
    for (int i = 0; i < n; i++) begin
      d = rnd ? 32'($urandom) : base + 32'(i);
      model_mem[(addr + i) % DEPTH] = d;
      drive_beat(1'b0, 1'b1, addr, len, tag, d);
    end
    model_wr_cnt += 32'(n);
  endtask

  task automatic wait_read_done(input int s0);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 5000) begin
      @(negedge user_clk);
      cyc++;
    end
    check_eq("cpl_drain", 64'(exp_q.size()), 64'(0));
    @(posedge user_clk);
    #1;
    check_eq("cpl_count", 64'(sop_seen - s0), 64'(exp_cpls));
    @(negedge user_clk);
    check_eq("cpl_idle", 64'(cpl_valid), 64'(0));
    check_eq("fsm_idle", 64'(fsm_state), 64'(0));
    @(posedge user_clk);
    #1;
  endtask

  task automatic send_read(input int addr, input int len, input logic [7:0] tag, input bit check_lat);
    int s0;
    model_read(addr, len, tag);
    s0 = sop_seen;
    drive_beat(1'b1, 1'b0, addr, len, tag, 32'h0);
    if (check_lat) begin
      @(negedge user_clk);
      check_eq("cpl_lat_t1", 64'(cpl_valid), 64'(0));
      @(negedge user_clk);
      check_eq("cpl_lat_t2", 64'(cpl_valid), 64'(1));
    end
    wait_read_done(s0);
  endtask

  task automatic do_reset();
    @(posedge user_clk);
    #1;
    user_reset = 1'b1;
    req_valid  = 1'b0;
    req_sop    = 1'b0;
    @(negedge user_clk);
    check_eq("rst_req_ready", 64'(req_ready), 64'(0));
    @(posedge user_clk);
    #1;
    user_reset = 1'b0;
    @(negedge user_clk);
    check_eq("rst_cpl_valid", 64'(cpl_valid), 64'(0));
    check_eq("rst_cpl_sop", 64'(cpl_sop), 64'(0));
    check_eq("rst_cpl_eop", 64'(cpl_eop), 64'(0));
    check_eq("rst_cpl_tag", 64'(cpl_tag), 64'(0));
    check_eq("rst_cpl_bc", 64'(cpl_byte_count), 64'(0));
    check_eq("rst_cpl_data", 64'(cpl_data), 64'(0));
    check_eq("rst_proto_err", 64'(proto_err), 64'(0));
    check_eq("rst_wr_dw_cnt", 64'(wr_dw_cnt), 64'(0));
    check_eq("rst_fsm_state", 64'(fsm_state), 64'(0));
    check_eq("rst_req_ready_after", 64'(req_ready), 64'(1));
    model_wr_cnt = '0;
    exp_q.delete();
    @(posedge user_clk);
    #1;
  endtask

  initial begin
    int a;
    int l;
    int cyc;
    logic [7:0]  t;
    logic [31:0] d;

    do_reset();

    // give every RAM location a known value, then reset (RAM keeps its contents)
    send_write(0, 0, 8'h00, 1'b1, 32'h0);
    check_eq("wr_cnt_fill", 64'(wr_dw_cnt), 64'(1024));
    do_reset();

    // MWr then immediate MRd of the same four dwords
    send_write(16, 4, 8'h01, 1'b0, 32'hA0);
    check_eq("wr_cnt_case1", 64'(wr_dw_cnt), 64'(4));
    send_read(16, 4, 8'h05, 1'b1);

    // unaligned read split into 2/16/2, then the same under random stalls
    send_read(14, 20, 8'h22, 1'b1);
    stall_mode = 1'b1;
    send_read(14, 20, 8'h33, 1'b1);
    stall_mode = 1'b0;

    // write and read across the top of the address space
    send_write(DEPTH - 2, 4, 8'h44, 1'b1, 32'h0);
    check_eq("wr_cnt_wrap", 64'(wr_dw_cnt), 64'(model_wr_cnt));
    send_read(DEPTH - 2, 4, 8'h45, 1'b1);

    // len=0 read: 1024 dwords
    send_read(0, 0, 8'h55, 1'b0);

    // new header after 2 of 4 write beats
    check_eq("proto_err_clean", 64'(proto_err), 64'(0));
    drive_beat(1'b1, 1'b1, 256, 4, 8'h60, 32'h0);
    for (int i = 0; i < 2; i++) begin
      d = 32'($urandom);
      model_mem[256 + i] = d;
      drive_beat(1'b0, 1'b1, 256, 4, 8'h60, d);
    end
    model_wr_cnt += 32'd2;
    send_read(256, 4, 8'h61, 1'b1);
    check_eq("proto_err_midwrite", 64'(proto_err), 64'(1));
    check_eq("wr_cnt_partial", 64'(wr_dw_cnt), 64'(model_wr_cnt));

    // reset in the middle of a completion stream, then a fresh read
    model_read(512, 64, 8'h62);
    drive_beat(1'b1, 1'b0, 512, 64, 8'h62, 32'h0);
    cyc = 0;
    while (exp_q.size() > 59 && cyc < 200) begin
      @(negedge user_clk);
      cyc++;
    end
    check_eq("rd_progress", 64'(exp_q.size() <= 59), 64'(1));
    do_reset();
    send_read(512, 8, 8'h66, 1'b1);

    // non-sop beat while idle is dropped and flagged
    drive_beat(1'b0, 1'b1, 0, 0, 8'h00, 32'hDEAD_BEEF);
    @(negedge user_clk);
    check_eq("proto_err_idle", 64'(proto_err), 64'(1));
    check_eq("wr_cnt_idle_beat", 64'(wr_dw_cnt), 64'(model_wr_cnt));
    check_eq("fsm_after_drop", 64'(fsm_state), 64'(0));
    @(posedge user_clk);
    #1;
    send_read(0, 2, 8'h77, 1'b1);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      a          = $urandom_range(0, DEPTH - 1);
      l          = $urandom_range(1, 40);
      t          = 8'($urandom);
      stall_mode = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        send_write(a, l, t, 1'b1, 32'h0);
        check_eq("wr_cnt_rand", 64'(wr_dw_cnt), 64'(model_wr_cnt));
      end else begin
        send_read(a, l, t, 1'b1);
      end
    end
    stall_mode = 1'b0;

    check_eq("proto_err_sticky", 64'(proto_err), 64'(1));
    check_eq("exp_q_empty", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
